uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte FIFO between the CPU bus write strobe (write/value) and the UART transmitter.
- Absorbs bursts of CPU writes.
- Issues one-cycle write pulses to the transmitter only while it reports not busy.
- Removes the dropped-character problem of wiring the bus write straight to the UART.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2.
- WIDTH, 8, data width in bits.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rstn_i  input  1  reset; synchronous, active-low.
- write_i  input  1  bus write strobe, one entry per high cycle.
- val_i  input  WIDTH  write data, sampled when write_i=1.
- tx_busy_i  input  1  transmitter busy; high while a frame is shifting.
- tx_write_o  output  1  one-cycle load pulse to transmitter.
- tx_data_o  output  WIDTH  byte for transmitter; valid while tx_write_o=1.
- full_o  output  1  level == DEPTH.
- empty_o  output  1  level == 0.
- level_o  output  $clog2(DEPTH)+1  current entry count.
- overflow_o  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (rstn_i=0 at rising edge):
  - Pointers and level go to 0; FSM goes to IDLE.
  - tx_write_o=0, tx_data_o=0, full_o=0, empty_o=1, level_o=0, overflow_o=0.
  - Storage array is not cleared.
  - Reset mid-operation discards all queued entries. A tx_write_o pulse in flight is deasserted on the next cycle.
- Storage:
  - DEPTH x WIDTH register array.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - level is kept as a separate counter.
- Push:
  - Condition: write_i=1 and (level<DEPTH or a pop occurs in the same cycle).
  - Stores val_i at wr_ptr; wr_ptr+1.
  - Push when full with no same-cycle pop: data is dropped and pointers are unchanged.
- Pop: occurs in the cycle the FSM is in SEND; rd_ptr+1.
- Level update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- full_o, empty_o, level_o are registered and reflect state after the previous edge.
- FSM states:
  - IDLE: tx_write_o=0. If empty_o=0 and tx_busy_i=0, go to SEND; otherwise stay.
  - SEND: tx_write_o=1, tx_data_o=mem[rd_ptr] (registered on entry), pop. Always go to HOLD.
  - HOLD: tx_write_o=0, tx_data_o holds last value. Always go to IDLE. This is a one-cycle guard covering the transmitter's one-cycle busy assertion latency.
- Latency (empty FIFO, tx_busy_i=0):
  - write_i in cycle N → empty_o=0 in N+1 → tx_write_o=1 in N+2 → HOLD N+3 → IDLE N+4.
  - Back-to-back entries are spaced at least 3 cycles apart, plus any busy time.
- tx_busy_i high in IDLE stalls indefinitely with no pop. Entries keep accumulating up to DEPTH.
- write_i during SEND/HOLD is accepted normally under the push/level rules above.

Optional Feature:
- Macro: UART_TX_FIFO_OVF_EN.
- Defined:
  - overflow_o sets on the edge of any dropped push (write_i=1, full, no same-cycle pop).
  - It stays 1 until reset.
  - Setting and a drop in the same cycle as reset: reset wins.
- Not defined: overflow_o is tied to constant 0 and no flag register is synthesized. Drop behaviour is otherwise identical.

Test Plan:
- Single byte:
  - Stimulus: reset; write_i=1 val_i=0x41 at cycle N; tx_busy_i=0.
  - Response: tx_write_o=1 with tx_data_o=0x41 exactly in N+2 for one cycle; level_o 0→1→0; empty_o=1 again from N+3.
- Busy stall:
  - Stimulus: push 0x10, 0x11, 0x12 with tx_busy_i held 1 for 20 cycles, then 0.
  - Response: no tx_write_o while busy; level_o=3; afterwards pulses carry 0x10, 0x11, 0x12 in order, each at least 3 cycles apart.
- Overflow:
  - Stimulus: tx_busy_i=1; DEPTH+2 consecutive writes 0x00..0x11.
  - Response: full_o=1 after 16 writes; level_o=16; 0x10 and 0x11 are dropped.
  - With macro: overflow_o=1 and sticky. Without macro: overflow_o=0.
  - Drain yields 0x00..0x0F.
- Simultaneous push/pop at full:
  - Stimulus: fill to 16; release busy; write 0xAA in the SEND cycle.
  - Response: 0xAA is accepted; level_o stays 16; overflow_o stays 0; 0xAA is the last byte out.
- Reset mid-operation:
  - Stimulus: 5 entries queued; rstn_i=0 for one cycle during SEND.
  - Response: next cycle tx_write_o=0, level_o=0, empty_o=1, overflow_o=0; no further pulses until a new write.
- Wrap-around:
  - Stimulus: 40 writes of an incrementing pattern, interleaved with random tx_busy_i.
  - Response: output sequence matches input exactly, with pointers wrapping past DEPTH.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a CPU write strobe and a UART transmitter; feeds one-cycle load pulses when the TX is idle.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     write_i,
   input  logic [WIDTH-1:0]         val_i,
   input  logic                     tx_busy_i,
   output logic                     tx_write_o,
   output logic [WIDTH-1:0]         tx_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      level, level_nxt;
   logic             push, pop, load;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) state <= IDLE;
      else         state <= state_nxt;
   end

   // HOLD gives the transmitter one cycle to raise busy before the next decision.
   always_comb begin
      state_nxt  = state;
      tx_write_o = 1'b0;
      pop        = 1'b0;
      load       = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty_o && !tx_busy_i) begin
               state_nxt = SEND;
               load      = 1'b1;
            end
         end
         SEND: begin
            tx_write_o = 1'b1;
            pop        = 1'b1;
            state_nxt  = HOLD;
         end
         HOLD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign push = write_i && ((level != FULL_LVL) || pop);

   always_comb begin
      level_nxt = level;
      unique case ({push, pop})
         2'b10:   level_nxt = level + (AW+1)'(1);
         2'b01:   level_nxt = level - (AW+1)'(1);
         default: level_nxt = level;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= val_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         full_o    <= 1'b0;
         empty_o   <= 1'b1;
         tx_data_o <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         level   <= level_nxt;
         full_o  <= (level_nxt == FULL_LVL);
         empty_o <= (level_nxt == '0);
         if (load) tx_data_o <= mem[rd_ptr];
      end
   end

   assign level_o = level;

`ifdef UART_TX_FIFO_OVF_EN
   logic drop;
   logic ovf;

   assign drop = write_i && (level == FULL_LVL) && !pop;

   always_ff @(posedge clk_i) begin
      if (!rstn_i)   ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
   end

   assign overflow_o = ovf;
`else
   assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: queue-based reference model checked every cycle plus literal spot checks.
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH = 16;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       write = 1'b0;
   logic [7:0] val = '0;
   logic       busy = 1'b0;
   logic       tx_write;
   logic [7:0] tx_data;
   logic       full, empty, overflow;
   logic [4:0] level;

   uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
      .clk_i(clk), .rstn_i(rstn), .write_i(write), .val_i(val), .tx_busy_i(busy),
      .tx_write_o(tx_write), .tx_data_o(tx_data), .full_o(full), .empty_o(empty),
      .level_o(level), .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_en = 0;

   // Reference: FIFO contents as a queue; a pulse may only follow two pulse-free cycles.
   logic [7:0] q[$];
   bit         m_pulse = 0, m_prev = 0, m_nxt, m_ovf = 0;
   logic [7:0] m_data = '0;

   logic [7:0] got[$];
   int         got_cyc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (!rstn) begin
         q.delete();
         m_pulse = 0;
         m_prev  = 0;
         m_data  = '0;
         m_ovf   = 0;
         chk_en  = 1;
      end else begin
         m_nxt = !m_pulse && !m_prev && (q.size() > 0) && !busy;
         if (m_nxt) m_data = q[0];
         if (m_pulse) void'(q.pop_front());
         if (write) begin
            if (q.size() < DEPTH) q.push_back(val);
`ifdef UART_TX_FIFO_OVF_EN
            else m_ovf = 1;
`endif
         end
         m_prev  = m_pulse;
         m_pulse = m_nxt;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_tx_write", 32'(tx_write), 32'(m_pulse));
         chk("m_tx_data", 32'(tx_data), 32'(m_data));
         chk("m_level", 32'(level), 32'(q.size()));
         chk("m_full", 32'(full), 32'(q.size() == DEPTH));
         chk("m_empty", 32'(empty), 32'(q.size() == 0));
         chk("m_overflow", 32'(overflow), 32'(m_ovf));
         if (tx_write === 1'b1) begin
            got.push_back(tx_data);
            got_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b0; write = 1'b0; busy = 1'b0;
      tick(2);
      rstn = 1'b1;
   endtask

   task automatic wait_pulse(input int limit, input string name);
      int i;
      for (i = 0; i < limit; i++) begin
         if (tx_write === 1'b1) break;
         tick();
      end
      if (i == limit) chk(name, 32'(tx_write), 32'd1);
   endtask

   task automatic wait_count(input int n, input int limit, input string name);
      for (int i = 0; i < limit; i++) begin
         if (got.size() >= n) break;
         tick();
      end
      chk(name, 32'(got.size()), 32'(n));
   endtask

   initial begin
      int b;
      do_reset();
      chk("rst_tx_write", 32'(tx_write), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      tick();

      // Single byte: write in cycle N, pulse in exactly N+2.
      write = 1'b1; val = 8'h41;
      tick(); write = 1'b0;
      chk("sb_level_n1", 32'(level), 32'd1);
      chk("sb_empty_n1", 32'(empty), 32'd0);
      chk("sb_txw_n1", 32'(tx_write), 32'd0);
      tick();
      chk("sb_txw_n2", 32'(tx_write), 32'd1);
      chk("sb_data_n2", 32'(tx_data), 32'h41);
      tick();
      chk("sb_txw_n3", 32'(tx_write), 32'd0);
      chk("sb_level_n3", 32'(level), 32'd0);
      chk("sb_empty_n3", 32'(empty), 32'd1);
      tick(4);

      // Busy stall.
      busy = 1'b1;
      b = got.size();
      for (int i = 0; i < 3; i++) begin
         write = 1'b1; val = 8'(8'h10 + i);
         tick();
      end
      write = 1'b0;
      tick(20);
      chk("bs_no_pulse", 32'(got.size()), 32'(b));
      chk("bs_level", 32'(level), 32'd3);
      busy = 1'b0;
      wait_count(b + 3, 40, "bs_count");
      if (got.size() >= b + 3) begin
         for (int i = 0; i < 3; i++) chk("bs_byte", 32'(got[b+i]), 32'(8'h10 + i));
         for (int i = 1; i < 3; i++)
            chk("bs_gap", 32'(got_cyc[b+i] - got_cyc[b+i-1] >= 3), 32'd1);
      end
      tick(4);

      // Overflow.
      busy = 1'b1;
      b = got.size();
      for (int i = 0; i < DEPTH + 2; i++) begin
         write = 1'b1; val = 8'(i);
         tick();
         if (i == DEPTH - 1) chk("ov_full16", 32'(full), 32'd1);
      end
      write = 1'b0;
      chk("ov_level", 32'(level), 32'd16);
      chk("ov_full", 32'(full), 32'd1);
`ifdef UART_TX_FIFO_OVF_EN
      chk("ov_flag", 32'(overflow), 32'd1);
`else
      chk("ov_flag", 32'(overflow), 32'd0);
`endif
      tick(3);
      busy = 1'b0;
      wait_count(b + DEPTH, 120, "ov_count");
      tick(4);
      chk("ov_extra", 32'(got.size()), 32'(b + DEPTH));
      if (got.size() >= b + DEPTH)
         for (int i = 0; i < DEPTH; i++) chk("ov_byte", 32'(got[b+i]), 32'(i));
`ifdef UART_TX_FIFO_OVF_EN
      chk("ov_sticky", 32'(overflow), 32'd1);
`endif

      // Simultaneous push/pop at full.
      do_reset();
      tick();
      busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         write = 1'b1; val = 8'(8'h20 + i);
         tick();
      end
      write = 1'b0;
      chk("sp_level_full", 32'(level), 32'd16);
      b = got.size();
      busy = 1'b0;
      wait_pulse(10, "sp_first_pulse");
      write = 1'b1; val = 8'hAA;
      tick();
      write = 1'b0;
      chk("sp_level", 32'(level), 32'd16);
      chk("sp_overflow", 32'(overflow), 32'd0);
      wait_count(b + DEPTH + 1, 120, "sp_count");
      if (got.size() >= b + DEPTH + 1) begin
         chk("sp_first", 32'(got[b]), 32'h20);
         chk("sp_last", 32'(got[b+DEPTH]), 32'hAA);
      end
      tick(4);

      // Reset during SEND.
      busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         write = 1'b1; val = 8'(8'h30 + i);
         tick();
      end
      write = 1'b0;
      busy = 1'b0;
      wait_pulse(10, "rm_pulse");
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("rm_txw", 32'(tx_write), 32'd0);
      chk("rm_level", 32'(level), 32'd0);
      chk("rm_empty", 32'(empty), 32'd1);
      chk("rm_overflow", 32'(overflow), 32'd0);
      b = got.size();
      tick(10);
      chk("rm_quiet", 32'(got.size()), 32'(b));

      // Wrap-around with random busy.
      b = got.size();
      for (int i = 0; i < 40; i++) begin
         write = 1'b1; val = 8'(8'h50 + i);
         busy = ($urandom_range(0, 3) == 0);
         tick();
         write = 1'b0;
         for (int k = 0; k < 3; k++) begin
            busy = ($urandom_range(0, 3) == 0);
            tick();
         end
      end
      busy = 1'b0;
      wait_count(b + 40, 200, "wr_count");
      if (got.size() >= b + 40)
         for (int i = 0; i < 40; i++) chk("wr_byte", 32'(got[b+i]), 32'(8'h50 + i));
      tick(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
